imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader.sv | 82 ++++++++
 tb/tb_imem_loader.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Boot loader: assembles a little-endian byte stream into 32-bit words and writes
// them to instruction memory from address 0 while holding the CPU stalled.
module imem_loader #(
  parameter int DEPTH = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [6:0]  num_words,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  input  logic [31:0] pc,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  output logic        cpu_stall,
  output logic        load_done,
  output logic [6:0]  word_cnt
);

  // Byte stream handshake: a byte moves on a rising edge where byte_valid and
  // byte_ready are both high; byte_ready depends only on the state, never on byte_valid.
  typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

  localparam logic [6:0] DEPTH_W = 7'(DEPTH);

  state_t      state;
  state_t      state_next;
  logic [1:0]  byte_idx;
  logic [31:0] asm_word;
  logic [6:0]  n_words;
  logic [6:0]  n_clamped;
  logic [6:0]  cnt_inc;
  logic        idle_or_done;

  assign n_clamped    = (num_words > DEPTH_W) ? DEPTH_W : num_words;
  assign cnt_inc      = word_cnt + 7'd1;
  assign idle_or_done = (state == IDLE) || (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      word_cnt <= '0;
      byte_idx <= '0;
      asm_word <= '0;
      n_words  <= '0;
    end else begin
      state <= state_next;
      if (idle_or_done && start) begin
        n_words  <= n_clamped;
        word_cnt <= '0;
        byte_idx <= '0;
        asm_word <= '0;
      end else if (state == RECV && byte_valid) begin
        asm_word[{byte_idx, 3'b000} +: 8] <= byte_in;
        byte_idx                          <= byte_idx + 2'd1;
      end else if (state == WRITE) begin
        word_cnt <= cnt_inc;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: if (start) state_next = (n_clamped == 7'd0) ? DONE : RECV;
      RECV:       if (byte_valid && byte_idx == 2'd3) state_next = WRITE;
      WRITE:      state_next = (cnt_inc == n_words) ? DONE : RECV;
      default:    state_next = IDLE;
    endcase
  end

  // While loading, the memory address port belongs to the loader; otherwise the CPU.
  assign byte_ready = (state == RECV);
  assign mem_we     = (state == WRITE);
  assign cpu_stall  = (state == RECV) || (state == WRITE);
  assign load_done  = (state == DONE);
  assign mem_addr   = cpu_stall ? {23'd0, word_cnt, 2'b00} : pc;
  assign mem_wdata  = asm_word;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: expected memory writes are built from the byte stream
// and compared against every observed mem_we pulse.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [6:0]  num_words;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic [31:0] pc;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic        cpu_stall;
  logic        load_done;
  logic [6:0]  word_cnt;

  int errors = 0;
  int checks = 0;
  int writes_seen = 0;
  logic [31:0] last_addr = '0;
  logic [63:0] exp_q[$];
  logic [7:0]  bq[$];

  imem_loader #(.DEPTH(64)) dut (
    .clk(clk), .rst(rst), .start(start), .num_words(num_words),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .pc(pc), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .cpu_stall(cpu_stall), .load_done(load_done), .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Scoreboard: sampled mid-cycle, after outputs settle and before inputs change.
  always @(posedge clk) begin
    #3;
    if (mem_we === 1'b1) begin
      writes_seen++;
      last_addr = mem_addr;
      if (exp_q.size() == 0) begin
        check("unexpected_write", {31'd0, mem_we}, 32'd0);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        check("wr_addr", mem_addr, e[63:32]);
        check("wr_data", mem_wdata, e[31:0]);
      end
    end
    if (cpu_stall === 1'b0) check("addr_passthrough", mem_addr, pc);
  end

  task automatic fill_bq(input int n);
    bq.delete();
    for (int i = 0; i < n; i++) bq.push_back(8'($urandom));
  endtask

  // Reference: word w is bytes 4w..4w+3 little-endian, written at byte address 4w.
  task automatic push_expected(input int n);
    for (int w = 0; w < n; w++)
      exp_q.push_back({32'(w * 4), bq[4*w+3], bq[4*w+2], bq[4*w+1], bq[4*w]});
  endtask

  task automatic do_start(input int n);
    start     = 1'b1;
    num_words = 7'(n);
    @(negedge clk);
    start     = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    for (int i = 0; i < gap; i++) begin
      check("stall_gap", {31'd0, cpu_stall}, 32'd1);
      @(negedge clk);
    end
    byte_valid = 1'b1;
    byte_in    = b;
    t = 0;
    while (!byte_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!byte_ready) check("ready_timeout", 32'd0, 32'd1);
    else @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic send_range(input int lo, input int hi, input int glo, input int ghi);
    for (int i = lo; i < hi; i++) send_byte(bq[i], int'($urandom_range(glo, ghi)));
  endtask

  task automatic wait_done();
    int t = 0;
    while (!load_done && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!load_done) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_load(input int n, input int glo, input int ghi);
    int nn;
    int w0;
    nn = (n > 64) ? 64 : n;
    w0 = writes_seen;
    push_expected(nn);
    do_start(n);
    send_range(0, 4 * nn, glo, ghi);
    wait_done();
    check("done_flag", {31'd0, load_done}, 32'd1);
    check("done_stall", {31'd0, cpu_stall}, 32'd0);
    check("done_word_cnt", {25'd0, word_cnt}, 32'(nn));
    check("write_count", 32'(writes_seen - w0), 32'(nn));
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int w0;
    rst = 1'b1; start = 1'b0; num_words = '0; byte_in = '0; byte_valid = 1'b0;
    pc = 32'h0000_1000;
    repeat (2) @(negedge clk);
    check("rst_ready", {31'd0, byte_ready}, 32'd0);
    check("rst_we", {31'd0, mem_we}, 32'd0);
    check("rst_stall", {31'd0, cpu_stall}, 32'd0);
    check("rst_done", {31'd0, load_done}, 32'd0);
    check("rst_word_cnt", {25'd0, word_cnt}, 32'd0);
    check("rst_addr", mem_addr, 32'h0000_1000);
    rst = 1'b0;
    @(negedge clk);

    // Two-word program with byte_valid held high
    bq = {8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    run_load(2, 0, 0);

    // Single word with three idle cycles before every byte
    bq = {8'h33, 8'h00, 8'h00, 8'h00};
    run_load(1, 3, 3);

    // Randomized programs, lengths and gaps
    for (int r = 0; r < 5; r++) begin
      int n;
      n  = int'($urandom_range(1, 8));
      pc = $urandom;
      fill_bq(4 * n);
      run_load(n, 0, int'($urandom_range(0, 3)));
    end

    // Oversized request clamps to the memory depth
    fill_bq(256);
    run_load(100, 0, 0);
    check("clamp_last_addr", last_addr, 32'h0000_00FC);

    // Reset after one word plus two bytes of the second
    pc = $urandom;
    fill_bq(8);
    w0 = writes_seen;
    push_expected(1);
    do_start(2);
    send_range(0, 6, 0, 0);
    rst = 1'b1;
    @(negedge clk);
    check("abort_ready", {31'd0, byte_ready}, 32'd0);
    check("abort_we", {31'd0, mem_we}, 32'd0);
    check("abort_stall", {31'd0, cpu_stall}, 32'd0);
    check("abort_done", {31'd0, load_done}, 32'd0);
    check("abort_word_cnt", {25'd0, word_cnt}, 32'd0);
    check("abort_addr", mem_addr, pc);
    rst = 1'b0;
    @(negedge clk);
    check("post_abort_stall", {31'd0, cpu_stall}, 32'd0);
    check("post_abort_done", {31'd0, load_done}, 32'd0);
    check("abort_writes", 32'(writes_seen - w0), 32'd1);
    check("abort_exp_q", 32'(exp_q.size()), 32'd0);

    // Empty load from IDLE reaches DONE one cycle after start
    w0 = writes_seen;
    do_start(0);
    check("empty_done", {31'd0, load_done}, 32'd1);
    check("empty_stall", {31'd0, cpu_stall}, 32'd0);
    @(negedge clk);
    check("empty_writes", 32'(writes_seen - w0), 32'd0);
    check("empty_word_cnt", {25'd0, word_cnt}, 32'd0);

    // Fresh load after the abort starts again at address 0
    fill_bq(4);
    run_load(1, 0, 1);

    // start pulsed mid-load changes nothing
    fill_bq(12);
    w0 = writes_seen;
    push_expected(3);
    do_start(3);
    send_range(0, 5, 0, 0);
    start = 1'b1;
    num_words = 7'd1;
    @(negedge clk);
    start = 1'b0;
    send_range(5, 12, 0, 1);
    wait_done();
    check("ign_word_cnt", {25'd0, word_cnt}, 32'd3);
    check("ign_writes", 32'(writes_seen - w0), 32'd3);
    check("ign_exp_q", 32'(exp_q.size()), 32'd0);

    // CPU address passthrough in DONE
    pc = 32'h0000_0024;
    #1;
    check("done_passthrough", mem_addr, 32'h0000_0024);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
